// File: rtl/uart_pkg.sv
// Shared UART definitions: controller states, prescale decode and parity helper.
// Used by both the transmitter and the receiver so their frame handling stays identical.
package uart_pkg;

    localparam int unsigned PrescaleW = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Only 1, 8, 16 and 32 cycles per bit are meaningful; anything else runs at 32.
    function automatic logic [PrescaleW-1:0] prescale_decode(input logic [PrescaleW-1:0] prescale);
        logic [PrescaleW-1:0] n;
        case (prescale)
            6'd1:    n = 6'd1;
            6'd8:    n = 6'd8;
            6'd16:   n = 6'd16;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

    // Zero-extended data leaves the reduction unchanged, so any word up to 32 bits fits.
    function automatic logic calc_parity(input logic [31:0] data, input logic par_typ);
        return par_typ ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Per-bit cycle counter: counts 0..n-1 while enabled and flags the last cycle of each bit.
// Wraps to 0 at every bit end, so each new state starts on a fresh count.
module uart_tx_bit_timer
    import uart_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [PrescaleW-1:0] n,
    output logic                 bit_end_c
);

    logic [PrescaleW-1:0] cnt_q;
    logic [PrescaleW-1:0] cnt_d;

    always_comb begin
        bit_end_c = enable && (cnt_q == (n - PrescaleW'(1)));
        cnt_d     = cnt_q + PrescaleW'(1);
        if (!enable || bit_end_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: serialises P_DATA as start / data (LSB first) / optional parity / stop.
// Busy drops in the last stop cycle so a held DATA_VALID starts the next frame with no gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned Width = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [Width-1:0]     P_DATA,
    input  logic                 DATA_VALID,
    input  logic                 PAR_EN,
    input  logic                 PAR_TYP,
    input  logic [PrescaleW-1:0] Prescale,
    output logic                 TX_OUT,
    output logic                 Busy
);

    localparam int unsigned BitCntW = (Width > 1) ? $clog2(Width) : 1;

    uart_state_e          state_q, state_d;
    logic [Width-1:0]     shift_q, shift_d;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic [PrescaleW-1:0] n_q, n_d;
    logic                 tx_q, tx_d;
    logic                 timer_en_c;
    logic                 bit_end_c;
    logic                 accept_c;
    logic                 last_bit_c;

    assign timer_en_c = (state_q != ST_IDLE);

    uart_tx_bit_timer u_bit_timer (
        .clk       (CLK),
        .rst_n     (RST),
        .enable    (timer_en_c),
        .n         (n_q),
        .bit_end_c (bit_end_c)
    );

    // Busy depends only on registered state and timer, never on an input.
    assign Busy       = (state_q != ST_IDLE) && !((state_q == ST_STOP) && bit_end_c);
    assign accept_c   = DATA_VALID && !Busy;
    assign last_bit_c = (bit_cnt_q == BitCntW'(Width - 1));
    assign TX_OUT     = tx_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            n_q       <= 6'd32;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            n_q       <= n_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept_c) state_d = ST_START;
            ST_START:  if (bit_end_c) state_d = ST_DATA;
            ST_DATA:   if (bit_end_c && last_bit_c) state_d = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end_c) state_d = ST_STOP;
            ST_STOP:   if (bit_end_c) state_d = accept_c ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Frame configuration is frozen at acceptance; the line level follows the next state.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        n_d       = n_q;
        tx_d      = 1'b1;
        if (accept_c) begin
            shift_d   = P_DATA;
            bit_cnt_d = '0;
            par_en_d  = PAR_EN;
            par_bit_d = calc_parity(32'(P_DATA), PAR_TYP);
            n_d       = prescale_decode(Prescale);
        end else if ((state_q == ST_DATA) && bit_end_c) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = last_bit_c ? '0 : bit_cnt_q + BitCntW'(1);
        end
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            default:   tx_d = 1'b1;
        endcase
    end

endmodule
